// File: rtl/riscv_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: IMEM program load, timed core reset
// release, halt-store detection and run-cycle counting. Define RUN_CTRL_WATCHDOG_EN for the run watchdog.
module riscv_run_ctrl #(
   parameter int unsigned DW         = 32,
   parameter int unsigned AW         = 32,
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned RST_CYCLES = 2,
   parameter int unsigned HALT_ADDR  = 100,
   parameter int unsigned HALT_VALUE = 25,
   parameter int unsigned MAX_CYCLES = 1000,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cmd_load,
   input  logic                          cmd_run,
   input  logic                          ld_valid,
   input  logic [DW-1:0]                 ld_data,
   input  logic                          ld_last,
   output logic                          ld_ready,
   output logic                          imem_we,
   output logic [$clog2(IMEM_WORDS):0]   imem_addr,
   output logic [DW-1:0]                 imem_wdata,
   output logic                          core_reset,
   input  logic                          dmem_we,
   input  logic [AW-1:0]                 dmem_addr,
   input  logic [DW-1:0]                 dmem_wdata,
   output logic                          busy,
   output logic                          done,
   output logic                          fault,
   output logic [CNT_W-1:0]              cycle_count,
   output logic [$clog2(IMEM_WORDS):0]   words_loaded
);

   localparam int unsigned IW = $clog2(IMEM_WORDS) + 1;
   localparam int unsigned HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [IW-1:0]    FULL      = IW'(IMEM_WORDS);
   localparam logic [HW-1:0]    HOLD_INIT = HW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] WD_LIMIT  = CNT_W'(MAX_CYCLES - 1);

`ifdef RUN_CTRL_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_RUN,
      S_DONE,
      S_FAULT
   } state_t;

   state_t        state, state_nx;
   logic [HW-1:0] hold_cnt;
   logic          xfer;
   logic          halt;
   logic          watchdog;

   assign halt     = dmem_we && (dmem_addr == AW'(HALT_ADDR)) && (dmem_wdata == DW'(HALT_VALUE));
   assign watchdog = WD_EN && (cycle_count == WD_LIMIT);

   // Status outputs decode the state register only, so they never see the inputs.
   assign busy       = (state == S_LOAD) || (state == S_HOLD) || (state == S_RUN);
   assign done       = (state == S_DONE);
   assign fault      = (state == S_FAULT);
   assign core_reset = (state != S_RUN);

   always_comb begin
      state_nx   = state;
      ld_ready   = (state == S_LOAD) && (words_loaded < FULL);
      xfer       = ld_valid && ld_ready;
      imem_we    = xfer;
      imem_addr  = words_loaded;
      imem_wdata = ld_data;
      case (state)
         S_IDLE, S_DONE, S_FAULT: begin
            if (cmd_load)
               state_nx = S_LOAD;
            else if (cmd_run)
               state_nx = S_HOLD;
         end
         S_LOAD: begin
            // A full IMEM without ld_last spends one cycle with ld_ready low, then faults.
            if (words_loaded == FULL)
               state_nx = S_FAULT;
            else if (xfer && ld_last)
               state_nx = S_IDLE;
         end
         S_HOLD: begin
            if (hold_cnt == '0)
               state_nx = S_RUN;
         end
         S_RUN: begin
            if (halt)
               state_nx = S_DONE;
            else if (watchdog)
               state_nx = S_FAULT;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         hold_cnt     <= '0;
         cycle_count  <= '0;
         words_loaded <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_IDLE, S_DONE, S_FAULT: begin
               if (cmd_load) begin
                  words_loaded <= '0;
               end else if (cmd_run) begin
                  cycle_count <= '0;
                  hold_cnt    <= HOLD_INIT;
               end
            end
            S_LOAD: begin
               if (xfer)
                  words_loaded <= words_loaded + IW'(1);
            end
            S_HOLD: begin
               if (hold_cnt != '0)
                  hold_cnt <= hold_cnt - HW'(1);
            end
            S_RUN: begin
               if (cycle_count != '1)
                  cycle_count <= cycle_count + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Bench for riscv_run_ctrl: phase-level reference model checked every cycle, plus
// directed scenarios with hand-computed literals (load, halt, watchdog, overflow, reset, commands).
module tb_riscv_run_ctrl;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned IMW   = 4;
   localparam int unsigned RST   = 2;
   localparam int unsigned HADDR = 100;
   localparam int unsigned HVAL  = 25;
   localparam int unsigned MAXC  = 20;
   localparam int unsigned CW    = 32;
   localparam int unsigned IW    = $clog2(IMW) + 1;

`ifdef RUN_CTRL_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_load = 1'b0;
   logic          cmd_run = 1'b0;
   logic          ld_valid = 1'b0;
   logic [DW-1:0] ld_data = '0;
   logic          ld_last = 1'b0;
   logic          ld_ready;
   logic          imem_we;
   logic [IW-1:0] imem_addr;
   logic [DW-1:0] imem_wdata;
   logic          core_reset;
   logic          dmem_we = 1'b0;
   logic [AW-1:0] dmem_addr = '0;
   logic [DW-1:0] dmem_wdata = '0;
   logic          busy;
   logic          done;
   logic          fault;
   logic [CW-1:0] cycle_count;
   logic [IW-1:0] words_loaded;

   riscv_run_ctrl #(
      .DW(DW), .AW(AW), .IMEM_WORDS(IMW), .RST_CYCLES(RST),
      .HALT_ADDR(HADDR), .HALT_VALUE(HVAL), .MAX_CYCLES(MAXC), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .cmd_load(cmd_load), .cmd_run(cmd_run),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_reset(core_reset), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .busy(busy), .done(done), .fault(fault),
      .cycle_count(cycle_count), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: the controller's phase as a name, plus plain counters.
   string   m_ph = "idle";
   int      m_words = 0;
   int      m_hold = 0;
   longint  m_cyc = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_ph = "idle"; m_words = 0; m_hold = 0; m_cyc = 0;
      end else if (m_ph == "idle" || m_ph == "done" || m_ph == "fault") begin
         if (cmd_load) begin
            m_ph = "load"; m_words = 0;
         end else if (cmd_run) begin
            m_ph = "hold"; m_hold = 0; m_cyc = 0;
         end
      end else if (m_ph == "load") begin
         if (m_words == IMW) m_ph = "fault";
         else if (ld_valid) begin
            m_words++;
            if (ld_last) m_ph = "idle";
         end
      end else if (m_ph == "hold") begin
         m_hold++;
         if (m_hold == RST) m_ph = "run";
      end else if (m_ph == "run") begin
         if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
         if (dmem_we && dmem_addr == HADDR && dmem_wdata == HVAL) m_ph = "done";
         else if (WD && m_cyc == MAXC) m_ph = "fault";
      end
   end

   logic [DW-1:0] mem [0:7];
   int            nwr = 0;
   bit            exp_ready;

   always @(negedge clk) begin
      if (chk_en) begin
         exp_ready = (m_ph == "load") && (m_words < IMW);
         chk("busy", 64'(busy), 64'(m_ph == "load" || m_ph == "hold" || m_ph == "run"));
         chk("done", 64'(done), 64'(m_ph == "done"));
         chk("fault", 64'(fault), 64'(m_ph == "fault"));
         chk("core_reset", 64'(core_reset), 64'(m_ph != "run"));
         chk("ld_ready", 64'(ld_ready), 64'(exp_ready));
         chk("imem_we", 64'(imem_we), 64'(exp_ready && ld_valid));
         chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
         chk("words_loaded", 64'(words_loaded), 64'(m_words));
         if (imem_we === 1'b1) begin
            chk("imem_addr", 64'(imem_addr), 64'(m_words));
            chk("imem_wdata", 64'(imem_wdata), 64'(ld_data));
            mem[imem_addr] = imem_wdata;
            nwr++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: simulation did not finish");
      $fatal(1);
   end

   int hc, rc, n;

   task automatic wait_hold();
      hc = 0;
      while (core_reset === 1'b1 && hc < 10) begin
         hc++;
         tick();
      end
      chk("hold_cycles", 64'(hc), 64'(RST));
   endtask

   initial begin
      tick();
      chk_en = 1'b1;
      reset = 1'b0;
      chk("rst_core_reset", 64'(core_reset), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cycle_count", 64'(cycle_count), 64'd0);
      chk("rst_words", 64'(words_loaded), 64'd0);

      // Load three words with ld_valid held high.
      cmd_load = 1'b1; tick(); cmd_load = 1'b0;
      nwr = 0;
      ld_valid = 1'b1; ld_data = 32'h11; tick();
      ld_data = 32'h22; tick();
      ld_data = 32'h33; ld_last = 1'b1; tick();
      ld_valid = 1'b0; ld_last = 1'b0;
      chk("load_writes", 64'(nwr), 64'd3);
      chk("load_words", 64'(words_loaded), 64'd3);
      chk("load_idle", 64'(busy), 64'd0);
      chk("load_mem0", 64'(mem[0]), 64'h11);
      chk("load_mem1", 64'(mem[1]), 64'h22);
      chk("load_mem2", 64'(mem[2]), 64'h33);

      // Run to halt in RUN cycle 7, with two near-miss stores before it.
      cmd_run = 1'b1; tick(); cmd_run = 1'b0;
      wait_hold();
      for (int i = 1; i < 7; i++) begin
         dmem_we = 1'b0;
         if (i == 3) begin dmem_we = 1'b1; dmem_addr = 32'd100; dmem_wdata = 32'd24; end
         if (i == 4) begin dmem_we = 1'b1; dmem_addr = 32'd104; dmem_wdata = 32'd25; end
         tick();
      end
      chk("run7_count", 64'(cycle_count), 64'd6);
      chk("run7_core_reset", 64'(core_reset), 64'd0);
      dmem_we = 1'b1; dmem_addr = 32'd100; dmem_wdata = 32'd25;
      tick();
      dmem_we = 1'b0;
      chk("halt_done", 64'(done), 64'd1);
      chk("halt_core_reset", 64'(core_reset), 64'd1);
      chk("halt_count", 64'(cycle_count), 64'd7);
      tick(); tick();
      chk("halt_count_held", 64'(cycle_count), 64'd7);

      // Both commands in DONE: load wins; then overflow with no ld_last.
      cmd_load = 1'b1; cmd_run = 1'b1; tick(); cmd_load = 1'b0; cmd_run = 1'b0;
      chk("both_busy", 64'(busy), 64'd1);
      chk("both_ready", 64'(ld_ready), 64'd1);
      chk("both_words", 64'(words_loaded), 64'd0);
      chk("both_core_reset", 64'(core_reset), 64'd1);
      nwr = 0; n = 0;
      ld_valid = 1'b1;
      while (fault !== 1'b1 && n < 10) begin
         ld_data = 32'hA0 + 32'(n);
         n++;
         tick();
      end
      ld_valid = 1'b0;
      chk("ovf_writes", 64'(nwr), 64'd4);
      chk("ovf_presented", 64'(n), 64'd5);
      chk("ovf_fault", 64'(fault), 64'd1);
      chk("ovf_words", 64'(words_loaded), 64'd4);
      chk("ovf_ready", 64'(ld_ready), 64'd0);
      chk("ovf_mem3", 64'(mem[3]), 64'hA3);

      // Long run from FAULT with an ignored store of 24; watchdog ends it at 20 cycles if built in.
      cmd_run = 1'b1; tick(); cmd_run = 1'b0;
      wait_hold();
      rc = 0;
      while (core_reset === 1'b0 && rc < 40) begin
         dmem_we = (rc == 9);
         dmem_addr = 32'd100; dmem_wdata = 32'd24;
         rc++;
         tick();
      end
      dmem_we = 1'b0;
      chk("wd_run_cycles", 64'(rc), WD ? 64'd20 : 64'd40);
      chk("wd_fault", 64'(fault), 64'(WD));
      chk("wd_count", 64'(cycle_count), WD ? 64'd20 : 64'd40);

      // Reset asserted in RUN cycle 5.
      reset = 1'b1; tick(); reset = 1'b0;
      cmd_run = 1'b1; tick(); cmd_run = 1'b0;
      wait_hold();
      for (int i = 1; i < 5; i++) tick();
      chk("mid_count", 64'(cycle_count), 64'd4);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_core_reset", 64'(core_reset), 64'd1);
      chk("mid_count_clr", 64'(cycle_count), 64'd0);
      chk("mid_done", 64'(done), 64'd0);
      chk("mid_fault", 64'(fault), 64'd0);
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
